// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the MIPS execute stage.
// Shift-add multiply and restoring divide operate on magnitudes, retiring
// BITS_PER_CYCLE bits per ITER cycle; signs are applied in FIX.
module muldiv_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic                  Cancel,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic                  DivByZero,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO
);
    localparam int DW = DATA_WIDTH;
    localparam int N  = DW / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;

    state_t          state_q, state_d;
    logic            is_div_q, is_div_d;
    logic            is_sgn_q, is_sgn_d;
    logic            neg_res_q, neg_res_d;   // product sign, or quotient sign
    logic            neg_rem_q, neg_rem_d;   // remainder follows the dividend
    logic [DW-1:0]   a_q, a_d;               // original operands, kept for the B==0 case
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   acc_q, acc_d;           // product high half / partial remainder
    logic [DW-1:0]   work_q, work_d;         // multiplier -> product low half / dividend -> quotient
    logic [DW-1:0]   dvs_q, dvs_d;           // multiplicand or divisor magnitude
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic            a_neg, b_neg;
    logic [DW:0]     t;
    logic [DW-1:0]   acc_n, work_n;
    logic [2*DW-1:0] prod;

    // Next-state and datapath: one step of the IDLE/PREP/ITER/FIX sequence per cycle
    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        is_sgn_d  = is_sgn_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        work_d    = work_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        a_neg     = 1'b0;
        b_neg     = 1'b0;
        t         = '0;
        acc_n     = acc_q;
        work_n    = work_q;
        prod      = '0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (!Op[2]) begin
                        a_d      = A;
                        b_d      = B;
                        is_div_d = Op[1];
                        is_sgn_d = ~Op[0];
                        state_d  = S_PREP;
                    end else if (Op == 3'b100) begin
                        hi_d = A;
                    end else if (Op == 3'b101) begin
                        lo_d = A;
                    end
                end
            end
            S_PREP: begin
                a_neg     = is_sgn_q & a_q[DW-1];
                b_neg     = is_sgn_q & b_q[DW-1];
                work_d    = a_neg ? -a_q : a_q;
                dvs_d     = b_neg ? -b_q : b_q;
                acc_d     = '0;
                cnt_d     = '0;
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                state_d   = S_ITER;
            end
            S_ITER: begin
                for (int i = 0; i < BITS_PER_CYCLE; i++) begin
                    if (is_div_q) begin
                        t      = {acc_n, work_n[DW-1]};
                        work_n = {work_n[DW-2:0], 1'b0};
                        if (t >= {1'b0, dvs_q}) begin
                            t         = t - {1'b0, dvs_q};
                            work_n[0] = 1'b1;
                        end
                        acc_n = t[DW-1:0];
                    end else begin
                        t      = {1'b0, acc_n} + (work_n[0] ? {1'b0, dvs_q} : {(DW+1){1'b0}});
                        work_n = {t[0], work_n[DW-1:1]};
                        acc_n  = t[DW:1];
                    end
                end
                acc_d  = acc_n;
                work_d = work_n;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (b_q == '0) begin
                        hi_d  = a_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        lo_d = neg_res_q ? -work_q : work_q;
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                    end
                end else begin
                    prod = {acc_q, work_q};
                    if (neg_res_q) prod = -prod;
                    {hi_d, lo_d} = prod;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush abandons the operation before anything architectural changes
        if (Cancel && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            dbz_d   = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State registers; reset clears control and HI/LO
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            is_sgn_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            work_q    <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            is_sgn_q  <= is_sgn_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            work_q    <= work_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign Busy      = (state_q != S_IDLE);
    assign Done      = done_q;
    assign DivByZero = dbz_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
endmodule
